// File: rtl/reg_scoreboard.sv
// Decode-stage RAW scoreboard: per-register outstanding-write counters with
// same-cycle writeback/squash bypass, saturation stall and sticky underflow flag.
module reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_src1,
  input  logic [ADDR_W-1:0] issue_src2,
  input  logic              issue_use2,
  input  logic              issue_wb_en,
  input  logic [ADDR_W-1:0] issue_dest,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic              sq_en,
  input  logic [ADDR_W-1:0] sq_dest,
  output logic              hazard_stall,
  output logic              issue_fire,
  output logic              busy,
  output logic              sb_error
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [NUM_REGS-1:0][CNT_W-1:0] eff;
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_next;
  logic [NUM_REGS-1:0]            under;
  logic [NUM_REGS-1:0]            nz_next;

  logic pend1;
  logic pend2;
  logic dest_full;
  logic hazard_raw;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic           hit_wb;
      logic           hit_sq;
      logic           hit_issue;
      logic [CNT_W:0] cnt_ext;
      logic [CNT_W:0] dec_ext;

      assign hit_wb    = wb_en && (wb_dest == ADDR_W'(gi));
      assign hit_sq    = sq_en && (sq_dest == ADDR_W'(gi));
      assign hit_issue = issue_fire && issue_wb_en && (issue_dest == ADDR_W'(gi));

      assign cnt_ext = {1'b0, cnt[gi]};
      assign dec_ext = (CNT_W+1)'(hit_wb) + (CNT_W+1)'(hit_sq);

      // Retiring more writes than are outstanding clamps at zero and flags an error.
      assign under[gi] = dec_ext > cnt_ext;
      assign eff[gi]   = under[gi] ? '0 : CNT_W'(cnt_ext - dec_ext);

      // No wrap possible: a firing issue never targets a saturated effective count.
      assign cnt_next[gi] = eff[gi] + CNT_W'(hit_issue);
      assign nz_next[gi]  = |cnt_next[gi];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt[gi] <= '0;
        end else begin
          cnt[gi] <= cnt_next[gi];
        end
      end
    end
  endgenerate

  assign pend1      = |eff[issue_src1];
  assign pend2      = issue_use2 && (|eff[issue_src2]);
  assign dest_full  = issue_wb_en && (eff[issue_dest] == CNT_MAX);
  assign hazard_raw = pend1 || pend2 || dest_full;

  assign hazard_stall = issue_valid && !rst && hazard_raw;
  assign issue_fire   = issue_valid && !rst && !hazard_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      sb_error <= 1'b0;
    end else begin
      busy     <= |nz_next;
      sb_error <= sb_error | (|under);
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed table-driven bench for reg_scoreboard plus hand-written
// reset and double-retire sequences.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic [4:0] issue_src1;
  logic [4:0] issue_src2;
  logic       issue_use2;
  logic       issue_wb_en;
  logic [4:0] issue_dest;
  logic       wb_en;
  logic [4:0] wb_dest;
  logic       sq_en;
  logic [4:0] sq_dest;
  logic       hazard_stall;
  logic       issue_fire;
  logic       busy;
  logic       sb_error;

  int checks = 0;
  int errors = 0;

  reg_scoreboard #(.NUM_REGS(32), .ADDR_W(5), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_src1(issue_src1), .issue_src2(issue_src2),
    .issue_use2(issue_use2), .issue_wb_en(issue_wb_en), .issue_dest(issue_dest),
    .wb_en(wb_en), .wb_dest(wb_dest), .sq_en(sq_en), .sq_dest(sq_dest),
    .hazard_stall(hazard_stall), .issue_fire(issue_fire),
    .busy(busy), .sb_error(sb_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] s1;
    logic [4:0] s2;
    logic       u2;
    logic       we;
    logic [4:0] d;
    logic       wb;
    logic [4:0] wbd;
    logic       sq;
    logic [4:0] sqd;
    logic       e_stall;
    logic       e_fire;
    logic       e_busy;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [4:0] s1, logic [4:0] s2, logic u2,
                              logic we, logic [4:0] d, logic wb, logic [4:0] wbd,
                              logic sq, logic [4:0] sqd, logic es, logic ef,
                              logic eb, logic ee);
    vec_t r;
    r.v = v; r.s1 = s1; r.s2 = s2; r.u2 = u2; r.we = we; r.d = d;
    r.wb = wb; r.wbd = wbd; r.sq = sq; r.sqd = sqd;
    r.e_stall = es; r.e_fire = ef; r.e_busy = eb; r.e_err = ee;
    return r;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t x);
    issue_valid = x.v;  issue_src1 = x.s1; issue_src2 = x.s2; issue_use2 = x.u2;
    issue_wb_en = x.we; issue_dest = x.d;  wb_en = x.wb; wb_dest = x.wbd;
    sq_en = x.sq; sq_dest = x.sqd;
  endtask

  task automatic chk_all(input string tag, input logic es, input logic ef,
                         input logic eb, input logic ee);
    chk({tag, ".stall"}, hazard_stall, es);
    chk({tag, ".fire"},  issue_fire,   ef);
    chk({tag, ".busy"},  busy,         eb);
    chk({tag, ".err"},   sb_error,     ee);
  endtask

  initial begin
    //            v  s1 s2 u2 we d  wb wbd sq sqd  stall fire busy err
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0)); // 0 idle
    vecs.push_back(mk(1, 1, 2, 1, 1, 3, 0, 0, 0, 0,  0, 1, 0, 0)); // 1 mark r3
    vecs.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0)); // 2 RAW on r3
    vecs.push_back(mk(1, 3, 0, 0, 0, 0, 1, 3, 0, 0,  0, 1, 1, 0)); // 3 wb bypass
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0)); // 4
    vecs.push_back(mk(1, 0, 0, 0, 1, 7, 0, 0, 0, 0,  0, 1, 0, 0)); // 5 mark r7
    vecs.push_back(mk(1, 1, 7, 1, 1, 7, 1, 7, 0, 0,  0, 1, 1, 0)); // 6 simul retire+issue
    vecs.push_back(mk(1, 7, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0)); // 7 r7 still pending
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 7, 0, 0,  0, 0, 1, 0)); // 8 retire r7
    vecs.push_back(mk(1, 0, 0, 0, 1, 4, 0, 0, 0, 0,  0, 1, 0, 0)); // 9 mark r4
    vecs.push_back(mk(1, 1, 4, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0)); // 10 use2=0
    vecs.push_back(mk(1, 1, 4, 1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0)); // 11 use2=1
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4, 0, 0,  0, 0, 1, 0)); // 12 retire r4
    vecs.push_back(mk(1, 0, 0, 0, 1, 9, 0, 0, 0, 0,  0, 1, 0, 0)); // 13 r9=1
    vecs.push_back(mk(1, 0, 0, 0, 1, 9, 0, 0, 0, 0,  0, 1, 1, 0)); // 14 r9=2 (WAW ok)
    vecs.push_back(mk(1, 0, 0, 0, 1, 9, 0, 0, 0, 0,  0, 1, 1, 0)); // 15 r9=3
    vecs.push_back(mk(1, 0, 0, 0, 1, 9, 0, 0, 0, 0,  1, 0, 1, 0)); // 16 saturated
    vecs.push_back(mk(1, 0, 0, 0, 1, 9, 1, 9, 0, 0,  0, 1, 1, 0)); // 17 wb frees a slot
    vecs.push_back(mk(1, 0, 0, 0, 1, 9, 0, 0, 0, 0,  1, 0, 1, 0)); // 18 saturated again
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 9, 1, 9,  0, 0, 1, 0)); // 19 wb+sq -> 1
    vecs.push_back(mk(1, 9, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0)); // 20 r9 still 1
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 9, 0, 0,  0, 0, 1, 0)); // 21 r9 -> 0
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0)); // 22
    vecs.push_back(mk(1, 0, 0, 0, 1, 2, 0, 0, 0, 0,  0, 1, 0, 0)); // 23 mark r2
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2,  0, 0, 1, 0)); // 24 squash r2
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0)); // 25 busy clear
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 6, 0, 0,  0, 0, 0, 0)); // 26 underflow r6
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1)); // 27 err set
    vecs.push_back(mk(1, 0, 0, 0, 1, 5, 0, 0, 0, 0,  0, 1, 0, 1)); // 28 r5=1
    vecs.push_back(mk(1, 0, 0, 0, 1, 5, 0, 0, 0, 0,  0, 1, 1, 1)); // 29 r5=2
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1)); // 30 err sticky

    rst = 1'b1;
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_fire,
              vecs[i].e_busy, vecs[i].e_err);
      $display("vec %0d stall=%b fire=%b busy=%b err=%b", i,
               hazard_stall, issue_fire, busy, sb_error);
    end

    // Mid-run reset with r5 holding two writes.
    @(negedge clk);
    drive(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("pre_rst.stall", hazard_stall, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk_all("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    $display("mid-run reset stall=%b busy=%b err=%b", hazard_stall, busy, sb_error);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all("post_rst", 1'b0, 1'b1, 1'b0, 1'b0);

    // Writeback and squash to the same register with only one outstanding write.
    @(negedge clk);
    drive(mk(1, 0, 0, 0, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("dbl.mark_fire", issue_fire, 1'b1);
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 1, 8, 1, 8, 0, 0, 0, 0));
    #1;
    chk("dbl.busy_before", busy, 1'b1);
    chk("dbl.err_before", sb_error, 1'b0);
    @(negedge clk);
    drive(mk(1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk_all("dbl.after", 1'b0, 1'b1, 1'b0, 1'b1);
    $display("double retire busy=%b err=%b", busy, sb_error);

    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
